// File: rtl/hazard_control.sv
// Hazard control for the 5-stage RV32 pipeline: E-stage operand forwarding,
// load-use and branch stall/flush, multi-cycle execute sequencing, and a stall counter.

// Forwarding select for one E-stage source operand. M has priority over W; x0 is never forwarded.
module hazard_fwd_sel (
    input  logic [4:0] Rs_E,
    input  logic [4:0] Rd_M,
    input  logic [4:0] Rd_W,
    input  logic       RegWrite_M,
    input  logic       RegWrite_W,
    output logic [1:0] Fwd
);
    always_comb begin
        Fwd = 2'b00;
        if (RegWrite_M && (Rd_M != 5'd0) && (Rd_M == Rs_E)) begin
            Fwd = 2'b10;
        end else if (RegWrite_W && (Rd_W != 5'd0) && (Rd_W == Rs_E)) begin
            Fwd = 2'b01;
        end
    end
endmodule

module hazard_control #(
    parameter int MD_CYCLES = 4,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1_D,
    input  logic [4:0]       Rs2_D,
    input  logic [4:0]       Rs1_E,
    input  logic [4:0]       Rs2_E,
    input  logic [4:0]       Rd_E,
    input  logic [4:0]       Rd_M,
    input  logic [4:0]       Rd_W,
    input  logic             RegWrite_M,
    input  logic             RegWrite_W,
    input  logic             ResultSrc_E,
    input  logic             PCSrc_E,
    input  logic             MulDiv_E,
    output logic [1:0]       ForwardA_E,
    output logic [1:0]       ForwardB_E,
    output logic             Stall_F,
    output logic             Stall_D,
    output logic             Stall_E,
    output logic             Flush_D,
    output logic             Flush_E,
    output logic             Flush_M,
    output logic             MD_Start,
    output logic [CNT_W-1:0] Stall_Cnt
);
    localparam int NUM_OPS = 2;
    localparam logic [7:0] CNT_INIT = 8'(MD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic flush_d;
        logic flush_e;
        logic flush_m;
        logic md_start;
    } ctl_t;

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    ctl_t             ctl, ctl_hz, ctl_frz;
    logic             lu;

    logic [NUM_OPS-1:0][4:0] rs_e;
    logic [NUM_OPS-1:0][1:0] fwd;

    assign rs_e = {Rs2_E, Rs1_E};

    for (genvar g = 0; g < NUM_OPS; g++) begin : g_fwd
        hazard_fwd_sel u_sel (
            .Rs_E       (rs_e[g]),
            .Rd_M       (Rd_M),
            .Rd_W       (Rd_W),
            .RegWrite_M (RegWrite_M),
            .RegWrite_W (RegWrite_W),
            .Fwd        (fwd[g])
        );
    end

    assign lu = ResultSrc_E && (Rd_E != 5'd0) && ((Rd_E == Rs1_D) || (Rd_E == Rs2_D));

    // Branch/load-use response shared by IDLE and DONE; a taken branch kills the load-use stall.
    always_comb begin
        ctl_hz = '0;
        if (PCSrc_E) begin
            ctl_hz.flush_d = 1'b1;
            ctl_hz.flush_e = 1'b1;
        end else if (lu) begin
            ctl_hz.stall_f = 1'b1;
            ctl_hz.stall_d = 1'b1;
            ctl_hz.flush_e = 1'b1;
        end
    end

    always_comb begin
        ctl_frz         = '0;
        ctl_frz.stall_f = 1'b1;
        ctl_frz.stall_d = 1'b1;
        ctl_frz.stall_e = 1'b1;
        ctl_frz.flush_m = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctl     = '0;
        unique case (state_q)
            IDLE: begin
                // Starting an op holds E rather than flushing it, so the op itself is never lost.
                if (MulDiv_E && !PCSrc_E) begin
                    ctl          = ctl_frz;
                    ctl.md_start = 1'b1;
                    if (MD_CYCLES == 1) begin
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_INIT;
                    end
                end else begin
                    ctl = ctl_hz;
                end
            end
            BUSY: begin
                ctl = ctl_frz;
                if (cnt_q == 8'd1) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            DONE: begin
                ctl     = ctl_hz;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign stall_cnt_d = (ctl.stall_f && (stall_cnt_q != {CNT_W{1'b1}}))
                       ? stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Everything is held at zero while reset is asserted, independent of state.
    assign ForwardA_E = rst ? 2'b00 : fwd[0];
    assign ForwardB_E = rst ? 2'b00 : fwd[1];
    assign Stall_F    = !rst && ctl.stall_f;
    assign Stall_D    = !rst && ctl.stall_d;
    assign Stall_E    = !rst && ctl.stall_e;
    assign Flush_D    = !rst && ctl.flush_d;
    assign Flush_E    = !rst && ctl.flush_e;
    assign Flush_M    = !rst && ctl.flush_m;
    assign MD_Start   = !rst && ctl.md_start;
    assign Stall_Cnt  = rst ? '0 : stall_cnt_q;
endmodule
